// File: rtl/polar_to_rect.sv
// Iterative CORDIC polar-to-rectangular converter.
// Q16.16 modulus plus binary angle in, signed Q16.16 {re, im} out.
module polar_to_rect #(
  parameter int ITERATIONS = 32,
  parameter int GUARD      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] inP,
  output logic [63:0] outRI,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int W = 36 + GUARD;
  localparam logic [31:0] K_GAIN = 32'h4DBA_76D4;
  localparam logic signed [W-1:0] HALF = W'(1) << (GUARD - 1);
  localparam logic signed [W-1:0] MAXV = W'(32'h7FFF_FFFF);

  typedef enum logic [1:0] {IDLE, SCALE, ITER, FINISH} state_t;

  state_t state, state_nx;

  logic [63:0]          op_q;
  logic [4:0]           iter_q;
  logic                 flip_q;
  logic signed [W-1:0]  x_q, y_q;
  logic signed [31:0]   z_q;

  logic [31:0]          mod, ang;
  logic                 fold;
  logic [W-1:0]         x_init;
  logic signed [31:0]   atan_v;
  logic signed [W-1:0]  xs, ys;
  logic                 dpos;

  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    logic [31:0] v;
    v = '0;
    unique case (i)
      5'd0:  v = 32'h2000_0000;
      5'd1:  v = 32'h12E4_051E;
      5'd2:  v = 32'h09FB_385B;
      5'd3:  v = 32'h0511_11D4;
      5'd4:  v = 32'h028B_0D43;
      5'd5:  v = 32'h0145_D7E1;
      5'd6:  v = 32'h00A2_F61E;
      5'd7:  v = 32'h0051_7C55;
      5'd8:  v = 32'h0028_BE53;
      5'd9:  v = 32'h0014_5F2F;
      5'd10: v = 32'h000A_2F98;
      5'd11: v = 32'h0005_17CC;
      5'd12: v = 32'h0002_8BE6;
      5'd13: v = 32'h0001_45F3;
      5'd14: v = 32'h0000_A2FA;
      5'd15: v = 32'h0000_517D;
      5'd16: v = 32'h0000_28BE;
      5'd17: v = 32'h0000_145F;
      5'd18: v = 32'h0000_0A30;
      5'd19: v = 32'h0000_0518;
      5'd20: v = 32'h0000_028C;
      5'd21: v = 32'h0000_0146;
      5'd22: v = 32'h0000_00A3;
      5'd23: v = 32'h0000_0051;
      5'd24: v = 32'h0000_0029;
      5'd25: v = 32'h0000_0014;
      5'd26: v = 32'h0000_000A;
      5'd27: v = 32'h0000_0005;
      5'd28: v = 32'h0000_0003;
      5'd29: v = 32'h0000_0001;
      5'd30: v = 32'h0000_0001;
      5'd31: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // Undo the quadrant fold, drop guard bits (half-up) and clamp symmetric.
  function automatic logic [31:0] finish_comp(
    input logic signed [W-1:0] v,
    input logic                neg
  );
    logic signed [W-1:0] s, r;
    s = neg ? -v : v;
    r = (s + HALF) >>> GUARD;
    if (r > MAXV)
      return 32'h7FFF_FFFF;
    else if (r < -MAXV)
      return 32'h8000_0001;
    else
      return r[31:0];
  endfunction

  assign mod    = op_q[63:32];
  assign ang    = op_q[31:0];
  assign busy   = (state != IDLE);
  assign fold   = (ang[31] ^ ang[30]) && (ang != 32'h4000_0000);
  assign x_init = W'(({32'd0, mod} * {32'd0, K_GAIN}) >> (31 - GUARD));
  assign atan_v = atan_lut(iter_q);
  assign xs     = x_q >>> iter_q;
  assign ys     = y_q >>> iter_q;
  assign dpos   = ~z_q[31];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SCALE;
      SCALE:   state_nx = ITER;
      ITER:    if (iter_q == 5'(ITERATIONS - 1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      iter_q <= '0;
      flip_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      outRI  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= inP;
            err  <= 1'b0;
          end
        end
        SCALE: begin
          x_q    <= x_init;
          y_q    <= '0;
          z_q    <= fold ? ang + 32'h8000_0000 : ang;
          flip_q <= fold;
          iter_q <= '0;
        end
        ITER: begin
          x_q    <= dpos ? x_q - ys : x_q + ys;
          y_q    <= dpos ? y_q + xs : y_q - xs;
          z_q    <= dpos ? z_q - atan_v : z_q + atan_v;
          iter_q <= iter_q + 5'd1;
        end
        FINISH: begin
          done <= 1'b1;
          if (mod[31]) begin
            outRI <= '0;
            err   <= 1'b1;
          end else begin
            outRI <= {finish_comp(x_q, flip_q), finish_comp(y_q, flip_q)};
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/polar_to_rect.md
POLAR_TO_RECT -- requirements
Module: polar_to_rect

Interface
REQ-001 SHALL have parameter ITERATIONS, default 32, meaning the number of CORDIC micro-rotations; legal range 16..32.
REQ-002 SHALL have parameter GUARD, default 4, meaning the extra fractional guard bits in the x/y datapath.
REQ-003 SHALL have port clock, input, 1, master clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, request a conversion; sampled only in IDLE.
REQ-006 SHALL have port inP, input, 64, operand {mod[63:32], ang[31:0]}.
- mod: unsigned Q16.16.
- ang: signed binary angle, where 2^31 equals pi radians.
REQ-007 SHALL have port outRI, output, 64, registered result {re[63:32], im[31:0]}, each signed Q16.16.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking outRI/err valid.
REQ-009 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-010 SHALL have port err, output, 1, registered; set with done when mod[31]=1.

Function
REQ-011 SHALL implement an FSM with states IDLE, SCALE, ITER, FINISH.
REQ-012 SHALL, in IDLE with start=1 at edge 0, latch inP and enter SCALE; with start=0 it SHALL stay in IDLE.
REQ-013 SHALL ignore start in every state except IDLE: no queuing, and latched operands are unchanged.
REQ-014 SHALL perform quadrant folding at edge 1 (SCALE).
- If ang[31:30] is 00 or 11: z0=ang, flip=0.
- Otherwise: z0=ang+2^31 (mod 2^32 wrap), flip=1.
REQ-015 SHALL, at edge 1 (SCALE), set y0=0 and x0 = mod * 0x4DBA76D4 (K=0.6072529, Q1.31), truncated to Q16.(16+GUARD), then enter ITER with i=0.
REQ-016 SHALL perform one micro-rotation per ITER edge, i=0..ITERATIONS-1, using d = +1 if z>=0 else -1:
- x' = x - d*(y>>>i)
- y' = y + d*(x>>>i)
- z' = z - d*atan_i
REQ-017 SHALL use atan_i = round(atan(2^-i)/pi * 2^31); atan_0=0x20000000 and atan_1=0x12E4051E.
REQ-018 SHALL use arithmetic (sign-preserving) right shifts and a working width of at least 34+GUARD bits, so no intermediate overflow occurs for mod < 2^31.
REQ-019 SHALL enter FINISH after the edge that executes i=ITERATIONS-1.
REQ-020 SHALL, at the FINISH edge:
- Negate x and y if flip=1.
- Round half-up by GUARD bits.
- Saturate each component to [0x80000001, 0x7FFFFFFF].
- Load outRI, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-021 SHALL achieve a start-to-done latency of ITERATIONS+2 edges: with default parameters, done is high in the cycle after edge 34.
REQ-022 SHALL hold outRI and err from one done until the next done or reset; done SHALL be 0 at all other times.
REQ-023 SHALL, when mod[31]=1, still run the full latency and then output outRI=0, err=1, done=1; err SHALL clear at the next accepted start.
REQ-024 SHALL produce each component within ±4 LSB of round(mod*cos(theta)) and round(mod*sin(theta)) for mod <= 0x40000000 at ITERATIONS=32.
REQ-025 SHALL accept a start asserted in the cycle after done (state IDLE) as a new conversion, giving back-to-back throughput of one result per ITERATIONS+3 cycles.
REQ-026 SHALL produce an angle of exactly 0x40000000 or 0xC0000000 without flip, and 0x80000000 with flip.

Reset
REQ-027 SHALL, at the edge where reset=1, set state=IDLE, outRI=0, done=0, busy=0, err=0, and clear all datapath registers; reset overrides start.
REQ-028 SHALL, when reset is asserted mid-conversion, abort with no done pulse; the first start after reset deassertion SHALL be accepted normally.

Verification
REQ-029 SHALL verify the zero-angle case: reset, then start with inP={0x00010000, 0x00000000} -> done in the cycle after edge 34, outRI={0x00010000±4, 0x00000000±4}, err=0.
REQ-030 SHALL verify the +pi/2 case: inP={0x00020000, 0x40000000} -> outRI={0x00000000±4, 0x00020000±4}.
REQ-031 SHALL verify the flip path: inP={0x00010000, 0x80000000} -> outRI={0xFFFF0000±4, 0x00000000±4}.
REQ-032 SHALL verify start-while-busy: a second start with other data at edge 10 -> exactly one done, at edge 34, carrying the first operand's result, with busy high through edges 1..34.
REQ-033 SHALL verify reset mid-operation: reset at edge 20 -> busy=0 and outRI=0 after that edge, no done; a new start of {0x00010000, 0x20000000} -> outRI={0x0000B505±4, 0x0000B505±4}.
REQ-034 SHALL verify the error case: inP={0x80000000, 0x00000000} -> at the cycle after edge 34, done=1, err=1, outRI=0.
